// File: rtl/matmul_engine_v2_pkg.sv
// matmul_engine_v2_pkg
// Shared definitions for the matmul engine:
//   state_t  - sequencer state encoding
//   idx()    - flat element index of (row, col) in a max_dim-wide square matrix
//   sat_max/sat_min - signed clamp limits for a given accumulator width
package matmul_engine_v2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   function automatic int idx(input int i, input int j, input int max_dim);
      return i * max_dim + j;
   endfunction

   // For w=64 the shift wraps to -2^63 and the subtraction wraps back to 2^63-1.
   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/matmul_engine_v2_pe.sv
// matmul_engine_v2_pe
// One output-stationary signed MAC cell: accumulator, sticky overflow flag,
// wrap or clamp on overflow.
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   init_i           load accumulator with init_val_i and clear overflow
//   init_val_i       accumulator start value (bias or 0)
//   en_i             accumulate a_i*b_i this cycle
//   sat_mode_i       1: clamp on overflow, 0: keep low ACC_WIDTH bits
//   a_i, b_i         signed operands
//   acc_nxt_o        value the accumulator takes at the next edge
//   ov_nxt_o         value the overflow flag takes at the next edge
module matmul_engine_v2_pe
   import matmul_engine_v2_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         init_i,
   input  logic        [ACC_WIDTH-1:0]  init_val_i,
   input  logic                         en_i,
   input  logic                         sat_mode_i,
   input  logic signed [DATA_WIDTH-1:0] a_i,
   input  logic signed [DATA_WIDTH-1:0] b_i,
   output logic signed [ACC_WIDTH-1:0]  acc_nxt_o,
   output logic                         ov_nxt_o
);

   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

   logic signed [ACC_WIDTH-1:0]   acc_q;
   logic                          ov_q;
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH:0]     sum;
   logic                          sum_ovf;

   assign prod = a_i * b_i;
   // One guard bit: the sum is out of range exactly when the top two bits differ.
   assign sum = {acc_q[ACC_WIDTH-1], acc_q}
              + {{(ACC_WIDTH + 1 - 2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
   assign sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];

   always_comb begin
      acc_nxt_o = acc_q;
      ov_nxt_o  = ov_q;
      if (init_i) begin
         acc_nxt_o = init_val_i;
         ov_nxt_o  = 1'b0;
      end else if (en_i) begin
         ov_nxt_o = ov_q | sum_ovf;
         if (sum_ovf && sat_mode_i)
            acc_nxt_o = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
         else
            acc_nxt_o = sum[ACC_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc_q <= '0;
         ov_q  <= 1'b0;
      end else begin
         acc_q <= acc_nxt_o;
         ov_q  <= ov_nxt_o;
      end
   end

endmodule

// File: rtl/matmul_engine_v2.sv
// matmul_engine_v2
// C = A(NxK) * B(KxM) [+ C_in] on a MAX_DIM x MAX_DIM output-stationary MAC array.
// Operands are latched at start and streamed through a skewed systolic path.
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   start_i                 start request, honoured only in IDLE
//   acc_mode_i, sat_mode_i  bias-init enable, clamp-on-overflow enable
//   n_i, k_i, m_i           dimensions minus one
//   a_flat_i, b_flat_i      row-major operand matrices
//   c_flat_i                row-major bias matrix
//   result_o, ov_o          registered result and sticky overflow flags
//   busy_o, done_o          run in progress, one-cycle completion pulse
//
// state   | meaning
// IDLE    | waiting for start_i
// COMPUTE | streaming operands, t counts 0..N+K+M-3
// DONE    | result_o/ov_o final, done_o high for this cycle
module matmul_engine_v2
   import matmul_engine_v2_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int MAX_DIM    = 4,
   localparam int DIM_W     = $clog2(MAX_DIM)
) (
   input  logic                                   clk_i,
   input  logic                                   rst_n_i,
   input  logic                                   start_i,
   input  logic                                   acc_mode_i,
   input  logic                                   sat_mode_i,
   input  logic [DIM_W-1:0]                       n_i,
   input  logic [DIM_W-1:0]                       k_i,
   input  logic [DIM_W-1:0]                       m_i,
   input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]  a_flat_i,
   input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]  b_flat_i,
   input  logic [MAX_DIM*MAX_DIM*ACC_WIDTH-1:0]   c_flat_i,
   output logic [MAX_DIM*MAX_DIM*ACC_WIDTH-1:0]   result_o,
   output logic [MAX_DIM*MAX_DIM-1:0]             ov_o,
   output logic                                   busy_o,
   output logic                                   done_o
);

   localparam int CNT_W = $clog2(3 * MAX_DIM);
   localparam int NE    = MAX_DIM * MAX_DIM;

   state_t                         state_q, state_d;
   logic [CNT_W-1:0]               t_q;
   logic [DIM_W-1:0]               n_q, k_q, m_q;
   logic                           sat_q;
   logic signed [DATA_WIDTH-1:0]   a_lat  [MAX_DIM][MAX_DIM];
   logic signed [DATA_WIDTH-1:0]   b_lat  [MAX_DIM][MAX_DIM];
   // a travels right along a row, b travels down a column, one PE per cycle
   logic signed [DATA_WIDTH-1:0]   a_pipe [MAX_DIM][MAX_DIM-1];
   logic signed [DATA_WIDTH-1:0]   b_pipe [MAX_DIM-1][MAX_DIM];
   logic signed [DATA_WIDTH-1:0]   a_edge [MAX_DIM];
   logic signed [DATA_WIDTH-1:0]   b_edge [MAX_DIM];
   logic signed [DATA_WIDTH-1:0]   a_op   [MAX_DIM][MAX_DIM];
   logic signed [DATA_WIDTH-1:0]   b_op   [MAX_DIM][MAX_DIM];
   logic [NE-1:0]                  en;
   logic signed [ACC_WIDTH-1:0]    acc_nxt [NE];
   logic [NE-1:0]                  ov_nxt;
   logic [NE*ACC_WIDTH-1:0]        result_q;
   logic [NE-1:0]                  ov_q;
   int                             n_dim, k_dim, m_dim, t_int;
   logic                           accept, last;

   assign n_dim  = int'(n_q) + 1;
   assign k_dim  = int'(k_q) + 1;
   assign m_dim  = int'(m_q) + 1;
   assign t_int  = int'(t_q);
   assign accept = (state_q == ST_IDLE) && start_i;
   assign last   = (state_q == ST_COMPUTE) && (t_int == n_dim + k_dim + m_dim - 3);

   always_comb begin
      state_d = state_q;
      busy_o  = (state_q != ST_IDLE);
      done_o  = (state_q == ST_DONE);
      case (state_q)
         ST_IDLE:    if (start_i) state_d = ST_COMPUTE;
         ST_COMPUTE: if (last)    state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Row i enters the array i cycles late, column j enters j cycles late, so
   // PE(i,j) sees A[i][t-i-j] and B[t-i-j][j] at cycle t.
   always_comb begin
      for (int i = 0; i < MAX_DIM; i++) begin
         a_edge[i] = '0;
         b_edge[i] = '0;
         for (int kk = 0; kk < MAX_DIM; kk++) begin
            if ((t_int - i) == kk && kk < k_dim) begin
               a_edge[i] = a_lat[i][kk];
               b_edge[i] = b_lat[kk][i];
            end
         end
      end
      for (int i = 0; i < MAX_DIM; i++) begin
         for (int j = 0; j < MAX_DIM; j++) begin
            a_op[i][j] = (j == 0) ? a_edge[i] : a_pipe[i][(j == 0) ? 0 : j-1];
            b_op[i][j] = (i == 0) ? b_edge[j] : b_pipe[(i == 0) ? 0 : i-1][j];
            en[idx(i, j, MAX_DIM)] = (state_q == ST_COMPUTE) && (i < n_dim) && (j < m_dim)
                                   && (t_int >= i + j) && (t_int - i - j < k_dim);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         t_q      <= '0;
         n_q      <= '0;
         k_q      <= '0;
         m_q      <= '0;
         sat_q    <= 1'b0;
         result_q <= '0;
         ov_q     <= '0;
         for (int i = 0; i < MAX_DIM; i++)
            for (int j = 0; j < MAX_DIM; j++) begin
               a_lat[i][j] <= '0;
               b_lat[i][j] <= '0;
            end
         for (int i = 0; i < MAX_DIM; i++)
            for (int j = 0; j < MAX_DIM-1; j++) begin
               a_pipe[i][j] <= '0;
               b_pipe[j][i] <= '0;
            end
      end else begin
         if (accept) begin
            t_q   <= '0;
            n_q   <= n_i;
            k_q   <= k_i;
            m_q   <= m_i;
            sat_q <= sat_mode_i;
            for (int i = 0; i < MAX_DIM; i++)
               for (int j = 0; j < MAX_DIM; j++) begin
                  a_lat[i][j] <= a_flat_i[idx(i, j, MAX_DIM)*DATA_WIDTH +: DATA_WIDTH];
                  b_lat[i][j] <= b_flat_i[idx(i, j, MAX_DIM)*DATA_WIDTH +: DATA_WIDTH];
               end
         end else if (state_q == ST_COMPUTE) begin
            t_q <= t_q + CNT_W'(1);
         end
         if (state_q == ST_COMPUTE) begin
            for (int i = 0; i < MAX_DIM; i++)
               for (int j = 0; j < MAX_DIM-1; j++) begin
                  a_pipe[i][j] <= a_op[i][j];
                  b_pipe[j][i] <= b_op[j][i];
               end
         end
         // Capture the accumulators' next values so the last MAC lands in result.
         if (last) begin
            for (int i = 0; i < MAX_DIM; i++)
               for (int j = 0; j < MAX_DIM; j++) begin
                  if (i < n_dim && j < m_dim) begin
                     result_q[idx(i, j, MAX_DIM)*ACC_WIDTH +: ACC_WIDTH] <= acc_nxt[idx(i, j, MAX_DIM)];
                     ov_q[idx(i, j, MAX_DIM)] <= ov_nxt[idx(i, j, MAX_DIM)];
                  end else begin
                     result_q[idx(i, j, MAX_DIM)*ACC_WIDTH +: ACC_WIDTH] <= '0;
                     ov_q[idx(i, j, MAX_DIM)] <= 1'b0;
                  end
               end
         end
      end
   end

   assign result_o = result_q;
   assign ov_o     = ov_q;

   for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_row
      for (genvar gj = 0; gj < MAX_DIM; gj++) begin : g_col
         localparam int E = idx(gi, gj, MAX_DIM);
         matmul_engine_v2_pe #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
         ) u_pe (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .init_i     (accept),
            .init_val_i (acc_mode_i ? c_flat_i[E*ACC_WIDTH +: ACC_WIDTH] : '0),
            .en_i       (en[E]),
            .sat_mode_i (sat_q),
            .a_i        (a_op[gi][gj]),
            .b_i        (b_op[gi][gj]),
            .acc_nxt_o  (acc_nxt[E]),
            .ov_nxt_o   (ov_nxt[E])
         );
      end
   end

endmodule
